tt_capture: RTL and testbench

Sequential truth-table capture engine for the 7-input function-classification flow. On `start` it sweeps all 128 input minterms into an attached combinational (or pipelined) function-under-test, samples its single-bit output, and assembles the 128-bit truth-table signature. It compares that signature against an expected value. It drives the function's inputs and reads its output, so it sits in the bench/classification harness on the opposite side of each generated majority-network `top`.

---
 rtl/tt_pkg.sv | 22 ++
 rtl/tt_capture_if.sv | 31 +++
 rtl/tt_capture_sample_pipe.sv | 55 +++++
 rtl/tt_capture.sv | 141 ++++++++++++++
 tb/tb_tt_capture.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the 7-input truth-table capture flow.
// Widths here are the defaults; the RTL itself is parameterised on N_IN.
package tt_pkg;

  localparam int N_IN_DEF = 7;
  localparam int TT_W_DEF = 128;

  typedef logic [TT_W_DEF-1:0] tt_t;
  typedef logic [N_IN_DEF-1:0] minterm_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // 3-input majority, the building block of the functions under classification
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tt_capture_if.sv
// Handshake and data bundle between the capture engine and its harness.
// master = harness side (drives start/expected/f), slave = capture engine.
interface tt_capture_if
  import tt_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);

  localparam int TT_W = 2 ** N_IN;

  logic            start;
  logic [TT_W-1:0] exp_tt_i;
  logic            f_i;
  logic [N_IN-1:0] x_o;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] tt_o;
  logic            tt_valid;
  logic            match_o;

  modport master (
    output start, exp_tt_i, f_i,
    input  x_o, busy, done, tt_o, tt_valid, match_o
  );

  modport slave (
    input  start, exp_tt_i, f_i,
    output x_o, busy, done, tt_o, tt_valid, match_o
  );

endinterface

// File: rtl/tt_capture_sample_pipe.sv
// FN_LAT-deep {valid, index} delay line aligning issued minterms with the
// function output that answers them; a pure pass-through when FN_LAT is 0.
module tt_sample_pipe
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int FN_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_idx,
  output logic            out_valid,
  output logic [N_IN-1:0] out_idx
);

  if (FN_LAT == 0) begin : g_pass
    logic unused_pass_s;
    assign unused_pass_s = &{1'b0, clk, rst};
    assign out_valid     = in_valid;
    assign out_idx       = in_idx;
  end else begin : g_pipe
    logic [FN_LAT-1:0]           vld_q;
    logic [FN_LAT-1:0]           vld_d;
    logic [FN_LAT-1:0][N_IN-1:0] idx_q;
    logic [FN_LAT-1:0][N_IN-1:0] idx_d;

    // shift every stage one step towards the output each cycle
    always_comb begin
      vld_d    = vld_q;
      idx_d    = idx_q;
      vld_d[0] = in_valid;
      idx_d[0] = in_idx;
      for (int j = 1; j < FN_LAT; j++) begin
        vld_d[j] = vld_q[j-1];
        idx_d[j] = idx_q[j-1];
      end
    end

    // stage registers; reset flushes any in-flight samples
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        idx_q <= '0;
      end else begin
        vld_q <= vld_d;
        idx_q <= idx_d;
      end
    end

    assign out_valid = vld_q[FN_LAT-1];
    assign out_idx   = idx_q[FN_LAT-1];
  end

endmodule

// File: rtl/tt_capture.sv
// Sequential truth-table capture: sweeps all 2**N_IN minterms into a
// function-under-test, assembles the signature and compares it to exp_tt_i.
module tt_capture
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int FN_LAT = 0
) (
  input logic         clk,
  input logic         rst,
  tt_capture_if.slave bus
);

  localparam int              TT_W   = 2 ** N_IN;
  localparam logic [N_IN-1:0] X_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] X_ZERO = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] X_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [TT_W-1:0] TT_ZERO = {TT_W{1'b0}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] x_q, x_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic            match_q, match_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [TT_W-1:0] tt_wr_s;

  logic            pipe_in_valid_s;
  logic            pipe_out_valid_s;
  logic [N_IN-1:0] pipe_out_idx_s;
  logic            last_s;

  assign pipe_in_valid_s = (state_q == ST_SWEEP);

  tt_sample_pipe #(
    .N_IN   (N_IN),
    .FN_LAT (FN_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pipe_in_valid_s),
    .in_idx    (x_q),
    .out_valid (pipe_out_valid_s),
    .out_idx   (pipe_out_idx_s)
  );

  // the sweep ends when the sample for the top index emerges from the pipe
  assign last_s = pipe_out_valid_s && (pipe_out_idx_s == X_LAST);

  // signature with the currently emerging sample merged in
  always_comb begin
    tt_wr_s = tt_q;
    if (pipe_out_valid_s) begin
      tt_wr_s[pipe_out_idx_s] = bus.f_i;
    end else begin
      tt_wr_s = tt_q;
    end
  end

  // next-state logic for the FSM, counter and signature register
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    match_d = match_q;
    tt_d    = tt_q;
    case (state_q)
      ST_IDLE: begin
        x_d = X_ZERO;
        if (bus.start) begin
          state_d = ST_SWEEP;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          match_d = 1'b0;
          tt_d    = TT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP, ST_DRAIN: begin
        tt_d = tt_wr_s;
        if (last_s) begin
          state_d = ST_IDLE;
          x_d     = X_ZERO;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          match_d = (tt_wr_s == bus.exp_tt_i);
        end else if (state_q == ST_DRAIN) begin
          x_d = x_q;
        end else if (x_q == X_LAST) begin
          // counter parks on the top index; no second pass
          state_d = ST_DRAIN;
          x_d     = x_q;
        end else begin
          x_d = x_q + X_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = X_ZERO;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        match_d = 1'b0;
        tt_d    = TT_ZERO;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= X_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      tt_q    <= TT_ZERO;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      match_q <= match_d;
      tt_q    <= tt_d;
    end
  end

  assign bus.x_o      = x_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tt_o     = tt_q;
  assign bus.tt_valid = valid_q;
  assign bus.match_o  = match_q;

endmodule

// File: tb/tb_tt_capture.sv
// Directed bench for tt_capture: one combinational DUT (FN_LAT=0) and one
// driving a 2-register majority function (FN_LAT=2).
module tb_tt_capture;
  import tt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_capture_if #(.N_IN(7)) bus0 ();
  tt_capture_if #(.N_IN(7)) bus2 ();

  tt_capture #(.N_IN(7), .FN_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tt_capture #(.N_IN(7), .FN_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int   checks = 0;
  int   errors = 0;
  logic sel;
  logic start_r;
  int   mode;
  tt_t  exp_r;
  logic f0_s;
  logic d1_q, d2_q;

  localparam tt_t EXP_AA  = {32{4'hA}};
  localparam tt_t EXP_E8  = {16{8'hE8}};
  localparam tt_t EXP_TOP = {{32{1'b1}}, {96{1'b0}}};
  localparam tt_t EXP_ONE = {{127{1'b0}}, 1'b1};

  assign bus0.start    = start_r & ~sel;
  assign bus2.start    = start_r & sel;
  assign bus0.exp_tt_i = exp_r;
  assign bus2.exp_tt_i = exp_r;

  always_comb begin
    f0_s = 1'b0;
    case (mode)
      0:       f0_s = bus0.x_o[0];
      1:       f0_s = 1'b0;
      2:       f0_s = bus0.x_o[6] & bus0.x_o[5];
      default: f0_s = 1'b0;
    endcase
  end
  assign bus0.f_i = f0_s;

  always @(posedge clk) begin
    d1_q <= maj3(bus2.x_o[0], bus2.x_o[1], bus2.x_o[2]);
    d2_q <= d1_q;
  end
  assign bus2.f_i = d2_q;

  logic       done_s, busy_s, valid_s, match_s;
  logic [6:0] x_s;
  tt_t        tt_s;
  assign done_s  = sel ? bus2.done     : bus0.done;
  assign busy_s  = sel ? bus2.busy     : bus0.busy;
  assign valid_s = sel ? bus2.tt_valid : bus0.tt_valid;
  assign match_s = sel ? bus2.match_o  : bus0.match_o;
  assign x_s     = sel ? bus2.x_o      : bus0.x_o;
  assign tt_s    = sel ? bus2.tt_o     : bus0.tt_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait for done from the current cycle; lat counts cycles elapsed
  task automatic wait_done(output int lat, output int bcyc, output int bad_x);
    lat = 0; bcyc = 0; bad_x = 0;
    while (!done_s && lat < 400) begin
      if (busy_s) bcyc++;
      if (lat < 128 && x_s !== lat[6:0]) bad_x++;
      tick();
      lat++;
    end
  endtask

  task automatic run_sweep(output int lat, output int bcyc, output int bad_x);
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    wait_done(lat, bcyc, bad_x);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_r = 1'b0; sel = 1'b0; mode = 0; exp_r = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({bus0.x_o, bus0.busy, bus0.done, bus0.tt_valid, bus0.match_o} !== 11'd0) begin
      errors++; $display("FAIL reset_ctl0 got %h exp 0", {bus0.x_o, bus0.busy, bus0.done, bus0.tt_valid, bus0.match_o});
    end
    checks++;
    if ({bus2.x_o, bus2.busy, bus2.done, bus2.tt_valid, bus2.match_o} !== 11'd0) begin
      errors++; $display("FAIL reset_ctl2 got %h exp 0", {bus2.x_o, bus2.busy, bus2.done, bus2.tt_valid, bus2.match_o});
    end
    checks++;
    if (bus0.tt_o !== '0 || bus2.tt_o !== '0) begin
      errors++; $display("FAIL reset_tt got %h / %h exp 0", bus0.tt_o, bus2.tt_o);
    end
  endtask

  task automatic test_x0();
    int lat, bcyc, bad_x;
    sel = 1'b0; mode = 0; exp_r = EXP_AA;
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    checks++;
    if (busy_s !== 1'b1 || x_s !== 7'd0 || valid_s !== 1'b0) begin
      errors++; $display("FAIL x0_first_cycle got busy=%b x=%0d valid=%b exp 1 0 0", busy_s, x_s, valid_s);
    end
    wait_done(lat, bcyc, bad_x);
    checks++;
    if (lat !== 128) begin errors++; $display("FAIL x0_latency got %0d exp 128", lat); end
    checks++;
    if (bad_x !== 0) begin errors++; $display("FAIL x0_counter got %0d bad cycles exp 0", bad_x); end
    checks++;
    if (tt_s !== EXP_AA) begin errors++; $display("FAIL x0_tt got %h exp %h", tt_s, EXP_AA); end
    checks++;
    if (match_s !== 1'b1 || valid_s !== 1'b1 || busy_s !== 1'b0 || x_s !== 7'd0) begin
      errors++; $display("FAIL x0_done_cycle got m=%b v=%b b=%b x=%0d exp 1 1 0 0", match_s, valid_s, busy_s, x_s);
    end
    tick();
    checks++;
    if (done_s !== 1'b0 || valid_s !== 1'b1 || match_s !== 1'b1) begin
      errors++; $display("FAIL x0_after_done got d=%b v=%b m=%b exp 0 1 1", done_s, valid_s, match_s);
    end
  endtask

  task automatic test_maj_lat2();
    int lat, bcyc, bad_x;
    sel = 1'b1; exp_r = EXP_E8;
    run_sweep(lat, bcyc, bad_x);
    checks++;
    if (lat !== 130) begin errors++; $display("FAIL maj_latency got %0d exp 130", lat); end
    checks++;
    if (bcyc !== 130) begin errors++; $display("FAIL maj_busy_cycles got %0d exp 130", bcyc); end
    checks++;
    if (tt_s !== EXP_E8) begin errors++; $display("FAIL maj_tt got %h exp %h", tt_s, EXP_E8); end
    checks++;
    if (match_s !== 1'b1 || valid_s !== 1'b1) begin
      errors++; $display("FAIL maj_match got m=%b v=%b exp 1 1", match_s, valid_s);
    end
    tick();
  endtask

  task automatic test_zero_mismatch();
    int lat, bcyc, bad_x;
    sel = 1'b0; mode = 1; exp_r = EXP_ONE;
    run_sweep(lat, bcyc, bad_x);
    checks++;
    if (tt_s !== '0) begin errors++; $display("FAIL zero_tt got %h exp 0", tt_s); end
    checks++;
    if (match_s !== 1'b0 || valid_s !== 1'b1) begin
      errors++; $display("FAIL zero_match got m=%b v=%b exp 0 1", match_s, valid_s);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bcyc, bad_x;
    sel = 1'b0; mode = 0; exp_r = EXP_AA;
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
    repeat (60) tick();
    checks++;
    if (x_s !== 7'd60) begin errors++; $display("FAIL rstmid_x got %0d exp 60", x_s); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({x_s, busy_s, done_s, valid_s, match_s} !== 11'd0 || tt_s !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %h tt %h exp 0", {x_s, busy_s, done_s, valid_s, match_s}, tt_s);
    end
    mode = 1; exp_r = '0;
    run_sweep(lat, bcyc, bad_x);
    checks++;
    if (lat !== 128 || tt_s !== '0 || match_s !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart got lat=%0d tt=%h m=%b exp 128 0 1", lat, tt_s, match_s);
    end
    tick();
  endtask

  task automatic test_top_bits();
    int lat, bcyc, bad_x;
    sel = 1'b0; mode = 2; exp_r = EXP_TOP;
    run_sweep(lat, bcyc, bad_x);
    checks++;
    if (tt_s[127:96] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL top_hi got %h exp ffffffff", tt_s[127:96]); end
    checks++;
    if (tt_s[95:0] !== 96'd0) begin errors++; $display("FAIL top_lo got %h exp 0", tt_s[95:0]); end
    checks++;
    if (match_s !== 1'b1) begin errors++; $display("FAIL top_match got %b exp 1", match_s); end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat, bad_x, dones, busy_seen;
    sel = 1'b0; mode = 0; exp_r = EXP_AA;
    start_r = 1'b1;
    tick();
    lat = 0; bad_x = 0;
    while (!done_s && lat < 400) begin
      if (lat < 128 && x_s !== lat[6:0]) bad_x++;
      start_r = (lat == 10) || (lat == 127);
      tick();
      lat++;
    end
    start_r = 1'b0;
    checks++;
    if (lat !== 128 || bad_x !== 0) begin
      errors++; $display("FAIL ignore_sweep got lat=%0d badx=%0d exp 128 0", lat, bad_x);
    end
    dones = 0; busy_seen = 0;
    repeat (140) begin
      tick();
      if (done_s) dones++;
      if (busy_s) busy_seen++;
    end
    checks++;
    if (dones !== 0 || busy_seen !== 0) begin
      errors++; $display("FAIL ignore_extra got dones=%0d busy=%0d exp 0 0", dones, busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcyc, bad_x;
    sel = 1'b0; mode = 0; exp_r = EXP_AA;
    start_r = 1'b1;
    tick();
    wait_done(lat, bcyc, bad_x);
    checks++;
    if (lat !== 128) begin errors++; $display("FAIL b2b_first got %0d exp 128", lat); end
    tick();
    start_r = 1'b0;
    checks++;
    if (valid_s !== 1'b0 || busy_s !== 1'b1 || x_s !== 7'd0 || done_s !== 1'b0) begin
      errors++; $display("FAIL b2b_restart got v=%b b=%b x=%0d d=%b exp 0 1 0 0", valid_s, busy_s, x_s, done_s);
    end
    wait_done(lat, bcyc, bad_x);
    checks++;
    if (lat !== 128 || tt_s !== EXP_AA || match_s !== 1'b1) begin
      errors++; $display("FAIL b2b_second got lat=%0d tt=%h m=%b exp 128 aa.. 1", lat, tt_s, match_s);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_maj_lat2();
    test_zero_mismatch();
    test_reset_mid();
    test_top_bits();
    test_start_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
